shift_issue: RTL and testbench

Multi-cycle issue stage for the RV32E shift class (SLL/SRL/SRA, SLLI/SRLI/SRAI, and optionally C.SLLI/C.SRLI/C.SRAI).
- Accepts a dispatched instruction over a valid/ready handshake.
- Fetches operands over the core's single synchronous register-file read port.
- Drives the combinational shift unit and registers its result.
- Hands the result to writeback over a second valid/ready handshake.

---
 rtl/shift_issue_if.sv | 33 +++
 rtl/shift_issue.sv | 155 +++++++++++++++
 tb/tb_shift_issue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_if.sv
// Dispatch, register-file, shift-unit and writeback signals of the shift issue stage.
// slave: the issue stage itself; master: the surrounding core.
interface shift_issue_if;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic        InstrIsC;
  logic [3:0]  RfAddr;
  logic [31:0] RfData;
  logic [31:0] ShWord;
  logic [4:0]  ShShamt;
  logic        ShSignExtend;
  logic        ShShiftRight;
  logic [31:0] ShResult;
  logic        WbValid;
  logic        WbReady;
  logic [3:0]  WbRd;
  logic [31:0] WbData;
  logic        WbWrite;
  logic        WbIllegal;

  modport slave (
    input  InstrValid, Instr, InstrIsC, RfData, ShResult, WbReady,
    output InstrReady, RfAddr, ShWord, ShShamt, ShSignExtend, ShShiftRight,
           WbValid, WbRd, WbData, WbWrite, WbIllegal
  );

  modport master (
    output InstrValid, Instr, InstrIsC, RfData, ShResult, WbReady,
    input  InstrReady, RfAddr, ShWord, ShShamt, ShSignExtend, ShShiftRight,
           WbValid, WbRd, WbData, WbWrite, WbIllegal
  );
endinterface

// File: rtl/shift_issue.sv
// Multi-cycle RV32E shift issue stage: decode, operand fetch, shift, writeback handoff.
// Define SHIFT_ISSUE_COMPRESSED_EN to decode C.SLLI/C.SRLI/C.SRAI.
module shift_issue (
  input  logic           Clk,
  input  logic           Reset,
  shift_issue_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, READ_A, CAP_A, CAP_B, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic        is_imm_q, is_imm_d, right_q, right_d, arith_q, arith_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] opa_q, opa_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_write_q, wb_write_d, wb_illegal_q, wb_illegal_d;

  logic [6:0]  dec_f7;
  logic [2:0]  dec_f3;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, dec_shamt;
  logic        dec_imm, dec_right, dec_arith, dec_legal;

  always_comb begin
    dec_f7    = bus.Instr[31:25];
    dec_f3    = bus.Instr[14:12];
    dec_rd    = bus.Instr[11:7];
    dec_rs1   = bus.Instr[19:15];
    dec_rs2   = bus.Instr[24:20];
    dec_shamt = bus.Instr[24:20];
    dec_imm   = (bus.Instr[6:0] == 7'b0010011);
    dec_right = dec_f3[2];
    dec_arith = dec_f7[5];
    // imm[5] lives in funct7[0], so the funct7 match also rejects shamt >= 32
    dec_legal = (dec_imm || bus.Instr[6:0] == 7'b0110011) &&
                ((dec_f3 == 3'b001 && dec_f7 == 7'b0000000) ||
                 (dec_f3 == 3'b101 && (dec_f7 == 7'b0000000 || dec_f7 == 7'b0100000))) &&
                !dec_rd[4] && !dec_rs1[4] && (dec_imm || !dec_rs2[4]);
    if (bus.InstrIsC) begin
`ifdef SHIFT_ISSUE_COMPRESSED_EN
      dec_imm   = 1'b1;
      dec_shamt = bus.Instr[6:2];
      dec_rs2   = 5'd0;
      if (bus.Instr[1:0] == 2'b10 && bus.Instr[15:13] == 3'b000) begin
        dec_rd    = bus.Instr[11:7];
        dec_right = 1'b0;
        dec_arith = 1'b0;
        dec_legal = !bus.Instr[12] && !bus.Instr[11];
      end else if (bus.Instr[1:0] == 2'b01 && bus.Instr[15:13] == 3'b100 && !bus.Instr[11]) begin
        dec_rd    = {2'b01, bus.Instr[9:7]};
        dec_right = 1'b1;
        dec_arith = bus.Instr[10];
        dec_legal = !bus.Instr[12];
      end else begin
        dec_legal = 1'b0;
      end
      dec_rs1 = dec_rd;
`else
      dec_legal = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    is_imm_d     = is_imm_q;
    right_d      = right_q;
    arith_d      = arith_q;
    shamt_d      = shamt_q;
    opa_d        = opa_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_write_d   = wb_write_q;
    wb_illegal_d = wb_illegal_q;
    case (state_q)
      IDLE: if (bus.InstrValid) begin
        rs1_d        = dec_rs1[3:0];
        rs2_d        = dec_rs2[3:0];
        is_imm_d     = dec_imm;
        right_d      = dec_right;
        arith_d      = dec_arith;
        shamt_d      = dec_imm ? dec_shamt : 5'd0;
        opa_d        = '0;
        wb_rd_d      = dec_legal ? dec_rd[3:0] : 4'd0;
        wb_write_d   = dec_legal && (dec_rd != 5'd0);
        wb_illegal_d = !dec_legal;
        wb_data_d    = '0;
        state_d      = dec_legal ? READ_A : RESP;
      end
      READ_A: state_d = CAP_A;
      CAP_A: begin
        opa_d   = (rs1_q == 4'd0) ? 32'd0 : bus.RfData;
        state_d = is_imm_q ? EXEC : CAP_B;
      end
      CAP_B: begin
        shamt_d = (rs2_q == 4'd0) ? 5'd0 : bus.RfData[4:0];
        state_d = EXEC;
      end
      EXEC: begin
        // the shift unit's result is not trusted at zero shift amount
        wb_data_d = (shamt_q == 5'd0) ? opa_q : bus.ShResult;
        state_d   = RESP;
      end
      RESP: if (bus.WbReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.InstrReady   = (state_q == IDLE) && !Reset;
    bus.RfAddr       = (state_q == READ_A) ? rs1_q :
                       (state_q == CAP_A && !is_imm_q) ? rs2_q : 4'd0;
    bus.ShWord       = (state_q == EXEC) ? opa_q : 32'd0;
    bus.ShShamt      = (state_q == EXEC) ? shamt_q : 5'd0;
    bus.ShShiftRight = (state_q == EXEC) && right_q;
    bus.ShSignExtend = (state_q == EXEC) && arith_q;
    bus.WbValid      = (state_q == RESP);
    bus.WbRd         = wb_rd_q;
    bus.WbData       = wb_data_q;
    bus.WbWrite      = wb_write_q;
    bus.WbIllegal    = wb_illegal_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      is_imm_q     <= 1'b0;
      right_q      <= 1'b0;
      arith_q      <= 1'b0;
      shamt_q      <= '0;
      opa_q        <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_write_q   <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      is_imm_q     <= is_imm_d;
      right_q      <= right_d;
      arith_q      <= arith_d;
      shamt_q      <= shamt_d;
      opa_q        <= opa_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_write_q   <= wb_write_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: register file and shift unit modelled around the DUT.
// Covers the compressed forms when SHIFT_ISSUE_COMPRESSED_EN is defined.
module tb_shift_issue;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] rf [16];

  shift_issue_if bus ();

  shift_issue dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.RfData <= rf[bus.RfAddr];

  // Stand-in shift unit; returns junk at zero shamt so only the bypass can produce the right answer.
  always_comb begin
    if (bus.ShShamt == 5'd0)     bus.ShResult = 32'hBAD0_BAD0;
    else if (!bus.ShShiftRight)  bus.ShResult = bus.ShWord << bus.ShShamt;
    else if (bus.ShSignExtend)   bus.ShResult = $unsigned($signed(bus.ShWord) >>> bus.ShShamt);
    else                         bus.ShResult = bus.ShWord >> bus.ShShamt;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] f7, input logic [4:0] sh,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, sh, rs1, f3, rd, 7'b0010011};
  endfunction

  // Offer one instruction, then count edges from the accept edge to the first WbValid cycle.
  task automatic send(input logic [31:0] ins, input logic isc, output int lat, output logic rdy);
    bus.Instr = ins;
    bus.InstrIsC = isc;
    bus.InstrValid = 1'b1;
    rdy = bus.InstrReady;
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.WbValid) begin
        lat = i;
        break;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic drain();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++; if (bus.InstrReady !== 1'b0) $display("FAIL rst_ready_in_reset got %b exp 0", bus.InstrReady); else passes++;
    @(posedge Clk); #1;
    checks++; if (bus.WbValid !== 1'b0) $display("FAIL rst_wbvalid got %b exp 0", bus.WbValid); else passes++;
    checks++; if (bus.WbData !== 32'd0) $display("FAIL rst_wbdata got %h exp 0", bus.WbData); else passes++;
    checks++; if ({bus.WbRd, bus.WbWrite, bus.WbIllegal} !== 6'd0)
      $display("FAIL rst_wb_fields got %h exp 0", {bus.WbRd, bus.WbWrite, bus.WbIllegal}); else passes++;
    checks++; if ({bus.ShWord, bus.ShShamt, bus.RfAddr} !== 41'd0)
      $display("FAIL rst_sh_rf_idle got %h exp 0", {bus.ShWord, bus.ShShamt, bus.RfAddr}); else passes++;
    Reset = 1'b0;
    #1;
    checks++; if (bus.InstrReady !== 1'b1) $display("FAIL rst_ready_after got %b exp 1", bus.InstrReady); else passes++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.Instr = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3);
    bus.InstrIsC = 1'b0;
    bus.InstrValid = 1'b1;
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    checks++; if (bus.InstrReady !== 1'b0) $display("FAIL mid_ready_in_reset got %b exp 0", bus.InstrReady); else passes++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checks++; if (bus.InstrReady !== 1'b1) $display("FAIL mid_ready_after got %b exp 1", bus.InstrReady); else passes++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | bus.WbValid;
      @(posedge Clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL mid_no_response got wbvalid %b exp 0", seen); else passes++;
  endtask

  task automatic test_sll();
    int lat; logic rdy;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 1'b0, lat, rdy);
    checks++; if (rdy !== 1'b1) $display("FAIL sll_ready got %b exp 1", rdy); else passes++;
    checks++; if (lat != 5) $display("FAIL sll_latency got %0d exp 5", lat); else passes++;
    checks++; if (bus.WbData !== 32'h0000_0F10) $display("FAIL sll_data got %h exp 00000f10", bus.WbData); else passes++;
    checks++; if (bus.WbRd !== 4'd3) $display("FAIL sll_rd got %0d exp 3", bus.WbRd); else passes++;
    checks++; if ({bus.WbWrite, bus.WbIllegal} !== 2'b10) $display("FAIL sll_wr_ill got %b exp 10", {bus.WbWrite, bus.WbIllegal}); else passes++;
    drain();
  endtask

  task automatic test_srai_srli();
    int lat; logic rdy;
    send(enc_i(7'h20, 5'd31, 5'd6, 3'b101, 5'd5), 1'b0, lat, rdy);
    checks++; if (lat != 4) $display("FAIL srai_latency got %0d exp 4", lat); else passes++;
    checks++; if (bus.WbData !== 32'hFFFF_FFFF) $display("FAIL srai_data got %h exp ffffffff", bus.WbData); else passes++;
    checks++; if (bus.WbRd !== 4'd5) $display("FAIL srai_rd got %0d exp 5", bus.WbRd); else passes++;
    drain();
    send(enc_i(7'h00, 5'd31, 5'd6, 3'b101, 5'd5), 1'b0, lat, rdy);
    checks++; if (lat != 4) $display("FAIL srli_latency got %0d exp 4", lat); else passes++;
    checks++; if (bus.WbData !== 32'h0000_0001) $display("FAIL srli_data got %h exp 00000001", bus.WbData); else passes++;
    drain();
  endtask

  task automatic test_zero_shamt();
    int lat; logic rdy;
    logic [2:0] f3 [3];
    logic [6:0] f7 [3];
    f3[0] = 3'b001; f7[0] = 7'h00;
    f3[1] = 3'b101; f7[1] = 7'h00;
    f3[2] = 3'b101; f7[2] = 7'h20;
    for (int k = 0; k < 3; k++) begin
      send(enc_i(f7[k], 5'd0, 5'd8, f3[k], 5'd7), 1'b0, lat, rdy);
      checks++; if (bus.WbData !== 32'hDEAD_BEEF || lat != 4)
        $display("FAIL zero_shamt_%0d got data %h lat %0d exp deadbeef lat 4", k, bus.WbData, lat); else passes++;
      drain();
    end
  endtask

  task automatic test_illegal();
    int lat; logic rdy;
    send(enc_i(7'h01, 5'd1, 5'd8, 3'b001, 5'd7), 1'b0, lat, rdy);
    checks++; if (lat != 1) $display("FAIL ill_imm5_latency got %0d exp 1", lat); else passes++;
    checks++; if ({bus.WbIllegal, bus.WbWrite} !== 2'b10 || bus.WbData !== 32'd0)
      $display("FAIL ill_imm5_resp got ill/wr %b data %h exp 10 data 0", {bus.WbIllegal, bus.WbWrite}, bus.WbData); else passes++;
    drain();
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd17), 1'b0, lat, rdy);
    checks++; if (lat != 1) $display("FAIL ill_rd17_latency got %0d exp 1", lat); else passes++;
    checks++; if ({bus.WbIllegal, bus.WbWrite} !== 2'b10 || bus.WbData !== 32'd0)
      $display("FAIL ill_rd17_resp got ill/wr %b data %h exp 10 data 0", {bus.WbIllegal, bus.WbWrite}, bus.WbData); else passes++;
    drain();
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd0), 1'b0, lat, rdy);
    checks++; if (lat != 5) $display("FAIL srl_x0_latency got %0d exp 5", lat); else passes++;
    checks++; if (bus.WbData !== 32'h0000_000F || {bus.WbIllegal, bus.WbWrite} !== 2'b00)
      $display("FAIL srl_x0_resp got data %h ill/wr %b exp 0000000f 00", bus.WbData, {bus.WbIllegal, bus.WbWrite}); else passes++;
    drain();
  endtask

  task automatic test_stall();
    int lat; logic rdy;
    logic valid_ok, data_ok, ready_ok;
    bus.WbReady = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 1'b0, lat, rdy);
    checks++; if (lat != 5) $display("FAIL stall_latency got %0d exp 5", lat); else passes++;
    bus.Instr = enc_i(7'h00, 5'd1, 5'd8, 3'b001, 5'd7);
    bus.InstrValid = 1'b1;
    valid_ok = 1'b1; data_ok = 1'b1; ready_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      valid_ok = valid_ok & (bus.WbValid === 1'b1);
      data_ok  = data_ok & (bus.WbData === 32'h0000_0F10) & (bus.WbRd === 4'd3);
      ready_ok = ready_ok & (bus.InstrReady === 1'b0);
    end
    checks++; if (valid_ok !== 1'b1) $display("FAIL stall_valid_held got %b exp 1", valid_ok); else passes++;
    checks++; if (data_ok !== 1'b1) $display("FAIL stall_data_held got %b exp 1 (last %h)", data_ok, bus.WbData); else passes++;
    checks++; if (ready_ok !== 1'b1) $display("FAIL stall_ready_low got %b exp 1", ready_ok); else passes++;
    bus.InstrValid = 1'b0;
    bus.WbReady = 1'b1;
    @(posedge Clk); #1;
    checks++; if ({bus.WbValid, bus.InstrReady} !== 2'b01)
      $display("FAIL stall_release got valid/ready %b exp 01", {bus.WbValid, bus.InstrReady}); else passes++;
  endtask

  task automatic test_compressed();
    int lat; logic rdy;
    send(32'h0000_848D, 1'b1, lat, rdy);
`ifdef SHIFT_ISSUE_COMPRESSED_EN
    checks++; if (lat != 4) $display("FAIL c_srai_latency got %0d exp 4", lat); else passes++;
    checks++; if (bus.WbData !== 32'hFE00_0000 || bus.WbRd !== 4'd9 || bus.WbWrite !== 1'b1)
      $display("FAIL c_srai_resp got data %h rd %0d wr %b exp fe000000 9 1", bus.WbData, bus.WbRd, bus.WbWrite); else passes++;
    drain();
    send(32'h0000_948D, 1'b1, lat, rdy);
    checks++; if (lat != 1 || bus.WbIllegal !== 1'b1)
      $display("FAIL c_srai_bit12 got lat %0d ill %b exp 1 1", lat, bus.WbIllegal); else passes++;
`else
    checks++; if (lat != 1 || bus.WbIllegal !== 1'b1 || bus.WbWrite !== 1'b0)
      $display("FAIL c_disabled got lat %0d ill %b wr %b exp 1 1 0", lat, bus.WbIllegal, bus.WbWrite); else passes++;
`endif
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h5A5A_0000 + i;
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'h0000_00F1;
    rf[2] = 32'h0000_0024;
    rf[6] = 32'h8000_0000;
    rf[8] = 32'hDEAD_BEEF;
    rf[9] = 32'hF000_0000;
    bus.InstrValid = 1'b0;
    bus.Instr = 32'd0;
    bus.InstrIsC = 1'b0;
    bus.WbReady = 1'b1;
    test_reset();
    test_reset_mid();
    test_sll();
    test_srai_srli();
    test_zero_shamt();
    test_illegal();
    test_stall();
    test_compressed();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
